// File: rtl/thumb_decode_pkg.sv
// rtl/thumb_decode_pkg.sv - shared constants, bundle type and helpers for the Thumb decode stage
package thumb_decode_pkg;

  localparam logic [4:0] UOP_BRANCH = 5'd0;
  localparam logic [4:0] UOP_ADD    = 5'd1;
  localparam logic [4:0] UOP_SUB    = 5'd2;
  localparam logic [4:0] UOP_EOR    = 5'd4;
  localparam logic [4:0] UOP_CMP    = 5'd5;
  localparam logic [4:0] UOP_LSL    = 5'd6;
  localparam logic [4:0] UOP_MOV    = 5'd8;
  localparam logic [4:0] UOP_STR    = 5'd9;
  localparam logic [4:0] UOP_LDR    = 5'd10;
  localparam logic [4:0] UOP_BL     = 5'd11;

  localparam logic [3:0] COND_AL   = 4'b1110;
  localparam logic [3:0] COND_NONE = 4'b1111;
  localparam logic [3:0] LR_IDX    = 4'd14;

  // Canonical-width bundle; num carries offsets already sign-extended to 24 bits,
  // so a further sign extension to any wider datapath is always correct.
  typedef struct packed {
    logic [4:0]  uop;
    logic        num_to_rhs;
    logic [23:0] num;
    logic [3:0]  sel_p0;
    logic [3:0]  sel_p1;
    logic [3:0]  sel_in;
    logic        explose;
    logic [3:0]  branch_cond;
  } bundle_t;

  function automatic logic is_wide_prefix(input logic [15:0] hw);
    return (hw[15:13] == 3'b111) && (hw[12:11] != 2'b00);
  endfunction

endpackage

// File: rtl/thumb_decode_comb.sv
// rtl/thumb_decode_comb.sv - combinational decode of one 16-bit halfword or a 32-bit pair into a bundle
module thumb_decode_comb
  import thumb_decode_pkg::*;
#(
  parameter int WIDE_EN = 1
) (
  input  logic [15:0] hw1,
  input  logic [15:0] hw,
  input  logic        is_wide,
  output bundle_t     bundle
);

  logic s_bit;
  logic i1;
  logic i2;
  logic bl_ok;

  assign s_bit = hw1[10];
  assign i1    = ~(hw[13] ^ s_bit);
  assign i2    = ~(hw[11] ^ s_bit);
  assign bl_ok = (WIDE_EN != 0) && (hw1[15:11] == 5'b11110) &&
                 (hw[15:14] == 2'b11) && hw[12];

  always_comb begin
    bundle             = '0;
    bundle.branch_cond = COND_NONE;
    if (is_wide) begin
      if (bl_ok) begin
        bundle.uop         = UOP_BL;
        bundle.sel_in      = LR_IDX;
        bundle.branch_cond = COND_AL;
        bundle.num         = {s_bit, i1, i2, hw1[9:0], hw[10:0]};
      end else begin
        bundle.explose = 1'b1;
      end
    end else begin
      casez (hw[15:11])
        5'b00000: begin
          // A zero shift amount is the register move alias.
          if (hw[10:6] == 5'd0) begin
            bundle.uop    = UOP_MOV;
            bundle.sel_p0 = {1'b0, hw[5:3]};
            bundle.sel_in = {1'b0, hw[2:0]};
          end else begin
            bundle.uop        = UOP_LSL;
            bundle.num        = {19'd0, hw[10:6]};
            bundle.sel_p1     = {1'b0, hw[5:3]};
            bundle.sel_in     = {1'b0, hw[2:0]};
            bundle.num_to_rhs = 1'b1;
          end
        end
        5'b00011: begin
          bundle.uop    = hw[9] ? UOP_SUB : UOP_ADD;
          bundle.sel_p1 = {1'b0, hw[5:3]};
          bundle.sel_in = {1'b0, hw[2:0]};
          if (hw[10]) begin
            bundle.num        = {21'd0, hw[8:6]};
            bundle.num_to_rhs = 1'b1;
          end else begin
            bundle.sel_p0 = {1'b0, hw[8:6]};
          end
        end
        5'b001??: begin
          bundle.num        = {16'd0, hw[7:0]};
          bundle.num_to_rhs = 1'b1;
          case (hw[12:11])
            2'b00: begin
              bundle.uop    = UOP_MOV;
              bundle.sel_in = {1'b0, hw[10:8]};
            end
            2'b01: begin
              bundle.uop    = UOP_CMP;
              bundle.sel_p1 = {1'b0, hw[10:8]};
            end
            2'b10: begin
              bundle.uop    = UOP_ADD;
              bundle.sel_p1 = {1'b0, hw[10:8]};
              bundle.sel_in = {1'b0, hw[10:8]};
            end
            default: begin
              bundle.uop    = UOP_SUB;
              bundle.sel_p1 = {1'b0, hw[10:8]};
              bundle.sel_in = {1'b0, hw[10:8]};
            end
          endcase
        end
        5'b01000: begin
          if (hw[10:6] == 5'b00001) begin
            bundle.uop    = UOP_EOR;
            bundle.sel_p0 = {1'b0, hw[2:0]};
            bundle.sel_in = {1'b0, hw[2:0]};
            bundle.sel_p1 = {1'b0, hw[5:3]};
          end else begin
            bundle.explose = 1'b1;
          end
        end
        5'b0110?: begin
          bundle.uop        = hw[11] ? UOP_LDR : UOP_STR;
          bundle.sel_p1     = {1'b0, hw[5:3]};
          bundle.num        = {19'd0, hw[10:6]};
          bundle.num_to_rhs = 1'b1;
          if (hw[11]) bundle.sel_in = {1'b0, hw[2:0]};
          else        bundle.sel_p0 = {1'b0, hw[2:0]};
        end
        5'b11100: begin
          bundle.uop         = UOP_BRANCH;
          bundle.branch_cond = COND_AL;
          bundle.num         = {{13{hw[10]}}, hw[10:0]};
        end
        5'b1101?: begin
          // Conditions AL/NV in this slot are the undefined and SVC encodings.
          if (hw[11:9] == 3'b111) begin
            bundle.explose = 1'b1;
          end else begin
            bundle.uop         = UOP_BRANCH;
            bundle.branch_cond = hw[11:8];
            bundle.num         = {{16{hw[7]}}, hw[7:0]};
          end
        end
        default: bundle.explose = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/thumb_decode_stage.sv
// rtl/thumb_decode_stage.sv - pipelined Thumb decode stage with handshakes, flush and BL pair assembly
module thumb_decode_stage
  import thumb_decode_pkg::*;
#(
  parameter int NUM_W   = 32,
  parameter int SEL_W   = 4,
  parameter int UOP_W   = 5,
  parameter int WIDE_EN = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_halfword,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [UOP_W-1:0] uop,
  output logic             num_to_rhs,
  output logic [NUM_W-1:0] num,
  output logic [SEL_W-1:0] sel_p0,
  output logic [SEL_W-1:0] sel_p1,
  output logic [SEL_W-1:0] sel_in,
  output logic             explose,
  output logic [3:0]       branch_cond
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WIDE = 1'b1;

  logic [0:0]  state;
  logic [15:0] hw1;
  logic        wide;
  logic        accept;
  logic        deliver;
  logic        take_prefix;
  bundle_t     dec;

  assign in_ready    = !flush && (!out_valid || out_ready);
  assign accept      = in_valid && in_ready;
  assign deliver     = out_valid && out_ready;
  assign wide        = (state == ST_WIDE);
  assign take_prefix = !wide && is_wide_prefix(in_halfword);

  thumb_decode_comb #(
    .WIDE_EN (WIDE_EN)
  ) u_comb (
    .hw1     (hw1),
    .hw      (in_halfword),
    .is_wide (wide),
    .bundle  (dec)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      hw1         <= '0;
      out_valid   <= 1'b0;
      uop         <= '0;
      num_to_rhs  <= 1'b0;
      num         <= '0;
      sel_p0      <= '0;
      sel_p1      <= '0;
      sel_in      <= '0;
      explose     <= 1'b0;
      branch_cond <= COND_NONE;
    end else if (flush) begin
      state     <= ST_IDLE;
      hw1       <= '0;
      out_valid <= 1'b0;
    end else if (accept && take_prefix) begin
      // First half of a pair produces nothing; only a concurrent drain clears valid.
      state <= ST_WIDE;
      hw1   <= in_halfword;
      if (deliver) out_valid <= 1'b0;
    end else if (accept) begin
      state       <= ST_IDLE;
      out_valid   <= 1'b1;
      uop         <= UOP_W'(dec.uop);
      num_to_rhs  <= dec.num_to_rhs;
      num         <= NUM_W'(signed'(dec.num));
      sel_p0      <= SEL_W'(dec.sel_p0);
      sel_p1      <= SEL_W'(dec.sel_p1);
      sel_in      <= SEL_W'(dec.sel_in);
      explose     <= dec.explose;
      branch_cond <= dec.branch_cond;
    end else if (deliver) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_thumb_decode_stage.sv
// tb/tb_thumb_decode_stage.sv - self-checking bench for thumb_decode_stage
module tb_thumb_decode_stage;

  typedef struct packed {
    logic [4:0]  uop;
    logic        rhs;
    logic [31:0] num;
    logic [3:0]  p0;
    logic [3:0]  p1;
    logic [3:0]  in_s;
    logic        expl;
    logic [3:0]  cond;
  } exp_t;

  typedef struct {
    logic [15:0] hw;
    exp_t        e;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_halfword = 16'h0;
  logic        out_ready = 1'b1;
  logic        in_ready, out_valid, num_to_rhs, explose;
  logic [4:0]  uop;
  logic [31:0] num;
  logic [3:0]  sel_p0, sel_p1, sel_in, branch_cond;
  logic        n_in_ready, n_out_valid, n_num_to_rhs, n_explose;
  logic [4:0]  n_uop;
  logic [31:0] n_num;
  logic [3:0]  n_sel_p0, n_sel_p1, n_sel_in, n_branch_cond;

  int checks = 0;
  int errors = 0;
  int delivered = 0;
  exp_t mq[$];
  bit pend = 0;
  logic [15:0] m_hw1 = 16'h0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  thumb_decode_stage #(.NUM_W(32), .SEL_W(4), .UOP_W(5), .WIDE_EN(1)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_halfword(in_halfword), .out_valid(out_valid), .out_ready(out_ready), .uop(uop),
    .num_to_rhs(num_to_rhs), .num(num), .sel_p0(sel_p0), .sel_p1(sel_p1), .sel_in(sel_in),
    .explose(explose), .branch_cond(branch_cond)
  );

  thumb_decode_stage #(.NUM_W(32), .SEL_W(4), .UOP_W(5), .WIDE_EN(0)) dut_n (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(n_in_ready),
    .in_halfword(in_halfword), .out_valid(n_out_valid), .out_ready(out_ready), .uop(n_uop),
    .num_to_rhs(n_num_to_rhs), .num(n_num), .sel_p0(n_sel_p0), .sel_p1(n_sel_p1),
    .sel_in(n_sel_in), .explose(n_explose), .branch_cond(n_branch_cond)
  );

  function automatic exp_t dut_bundle();
    return exp_t'({uop, num_to_rhs, num, sel_p0, sel_p1, sel_in, explose, branch_cond});
  endfunction

  function automatic exp_t n_bundle();
    return exp_t'({n_uop, n_num_to_rhs, n_num, n_sel_p0, n_sel_p1, n_sel_in, n_explose, n_branch_cond});
  endfunction

  function automatic exp_t mk(int u, bit r, logic [31:0] n, int a, int b, int c, bit x, logic [3:0] cd);
    exp_t e;
    e.uop = 5'(u); e.rhs = r; e.num = n; e.p0 = 4'(a); e.p1 = 4'(b); e.in_s = 4'(c);
    e.expl = x; e.cond = cd;
    return e;
  endfunction

  function automatic bit is_prefix(logic [15:0] h);
    return int'(h[15:11]) >= 29;
  endfunction

  // Reference decoder written from the instruction rules with integer arithmetic.
  function automatic exp_t ref_decode(bit wide, logic [15:0] a, logic [15:0] b);
    exp_t e;
    int top5, off, cond;
    e = '0;
    e.cond = 4'hF;
    top5 = int'(b[15:11]);
    if (wide) begin
      if (int'(a[15:11]) == 30 && int'(b[15:14]) == 3 && b[12]) begin
        off = int'(a[9:0]) * 2048 + int'(b[10:0]);
        if (b[13] == a[10]) off += (1 << 22);
        if (b[11] == a[10]) off += (1 << 21);
        if (a[10]) off -= (1 << 23);
        e.uop = 11; e.in_s = 14; e.cond = 4'hE; e.num = 32'(off);
      end else e.expl = 1;
      return e;
    end
    if (top5 == 0) begin
      if (int'(b[10:6]) == 0) begin e.uop = 8; e.p0 = 4'(b[5:3]); e.in_s = 4'(b[2:0]); end
      else begin e.uop = 6; e.num = 32'(b[10:6]); e.p1 = 4'(b[5:3]); e.in_s = 4'(b[2:0]); e.rhs = 1; end
    end else if (top5 == 3) begin
      e.uop = b[9] ? 5'd2 : 5'd1;
      e.p1 = 4'(b[5:3]); e.in_s = 4'(b[2:0]);
      if (b[10]) begin e.num = 32'(b[8:6]); e.rhs = 1; end
      else e.p0 = 4'(b[8:6]);
    end else if (top5 >= 4 && top5 <= 7) begin
      e.num = 32'(b[7:0]); e.rhs = 1;
      if (top5 == 4) begin e.uop = 8; e.in_s = 4'(b[10:8]); end
      else if (top5 == 5) begin e.uop = 5; e.p1 = 4'(b[10:8]); end
      else begin e.uop = (top5 == 6) ? 5'd1 : 5'd2; e.p1 = 4'(b[10:8]); e.in_s = 4'(b[10:8]); end
    end else if (top5 == 8 && int'(b[10:6]) == 1) begin
      e.uop = 4; e.p0 = 4'(b[2:0]); e.in_s = 4'(b[2:0]); e.p1 = 4'(b[5:3]);
    end else if (top5 == 12 || top5 == 13) begin
      e.uop = (top5 == 13) ? 5'd10 : 5'd9;
      e.p1 = 4'(b[5:3]); e.num = 32'(b[10:6]); e.rhs = 1;
      if (top5 == 13) e.in_s = 4'(b[2:0]); else e.p0 = 4'(b[2:0]);
    end else if (top5 == 28) begin
      off = int'(b[10:0]);
      if (off >= 1024) off -= 2048;
      e.cond = 4'hE; e.num = 32'(off);
    end else if (top5 == 26 || top5 == 27) begin
      cond = int'(b[11:8]);
      if (cond >= 14) e.expl = 1;
      else begin
        off = int'(b[7:0]);
        if (off >= 128) off -= 256;
        e.cond = 4'(cond); e.num = 32'(off);
      end
    end else e.expl = 1;
    return e;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One cycle: drive at negedge, compare against the model, then advance the model.
  task automatic step(bit rst, bit fl, bit v, logic [15:0] h, bit rdy);
    bit exp_ready;
    @(negedge clk);
    reset = rst; flush = fl; in_valid = v; in_halfword = h; out_ready = rdy;
    #1;
    exp_ready = !fl && (mq.size() == 0 || rdy);
    check("in_ready", 64'(in_ready), 64'(exp_ready));
    check("out_valid", 64'(out_valid), 64'(mq.size() != 0));
    if (mq.size() != 0) check("bundle", 64'(dut_bundle()), 64'(mq[0]));
    if (rst || fl) begin
      mq.delete();
      pend = 0;
    end else begin
      if (mq.size() != 0 && rdy) begin
        void'(mq.pop_front());
        delivered++;
      end
      if (v && exp_ready) begin
        if (!pend && is_prefix(h)) begin
          pend = 1;
          m_hw1 = h;
        end else begin
          mq.push_back(ref_decode(pend, m_hw1, h));
          pend = 0;
        end
      end
    end
  endtask

  initial begin
    exp_t rst_e;
    int d0;
    logic [15:0] h;
    int r;

    tbl.push_back('{16'h188B, mk(1, 0, 32'h0, 2, 1, 3, 0, 4'hF)});
    tbl.push_back('{16'hD0FE, mk(0, 0, 32'hFFFFFFFE, 0, 0, 0, 0, 4'h0)});
    tbl.push_back('{16'h2105, mk(8, 1, 32'h5, 0, 0, 1, 0, 4'hF)});
    tbl.push_back('{16'h3907, mk(2, 1, 32'h7, 0, 1, 1, 0, 4'hF)});
    tbl.push_back('{16'hDE00, mk(0, 0, 32'h0, 0, 0, 0, 1, 4'hF)});
    tbl.push_back('{16'hDF00, mk(0, 0, 32'h0, 0, 0, 0, 1, 4'hF)});
    tbl.push_back('{16'h0008, mk(8, 0, 32'h0, 1, 0, 0, 0, 4'hF)});
    tbl.push_back('{16'h0111, mk(6, 1, 32'h4, 0, 2, 1, 0, 4'hF)});
    tbl.push_back('{16'h1C4A, mk(1, 1, 32'h1, 0, 1, 2, 0, 4'hF)});
    tbl.push_back('{16'h1A8B, mk(2, 0, 32'h0, 2, 1, 3, 0, 4'hF)});
    tbl.push_back('{16'h2A80, mk(5, 1, 32'h80, 0, 2, 0, 0, 4'hF)});
    tbl.push_back('{16'h33FF, mk(1, 1, 32'hFF, 0, 3, 3, 0, 4'hF)});
    tbl.push_back('{16'h404A, mk(4, 0, 32'h0, 2, 1, 2, 0, 4'hF)});
    tbl.push_back('{16'h6A53, mk(10, 1, 32'h9, 0, 2, 3, 0, 4'hF)});
    tbl.push_back('{16'h6053, mk(9, 1, 32'h1, 3, 2, 0, 0, 4'hF)});
    tbl.push_back('{16'hE400, mk(0, 0, 32'hFFFFFC00, 0, 0, 0, 0, 4'hE)});
    tbl.push_back('{16'hDC7F, mk(0, 0, 32'h7F, 0, 0, 0, 0, 4'hC)});
    tbl.push_back('{16'h4700, mk(0, 0, 32'h0, 0, 0, 0, 1, 4'hF)});

    repeat (2) @(posedge clk);
    step(1, 0, 0, 16'h0, 1);
    step(0, 0, 0, 16'h0, 1);
    rst_e = mk(0, 0, 32'h0, 0, 0, 0, 0, 4'hF);
    check("reset_valid", 64'(out_valid), 64'(0));
    check("reset_bundle", 64'(dut_bundle()), 64'(rst_e));

    for (int i = 0; i < tbl.size(); i++) begin
      step(0, 0, 1, tbl[i].hw, 1);
      @(posedge clk); #1;
      check("tbl_valid", 64'(out_valid), 64'(1));
      check("tbl_bundle", 64'(dut_bundle()), 64'(tbl[i].e));
    end
    step(0, 0, 0, 16'h0, 1);

    step(0, 0, 1, 16'hF7FF, 1);
    step(0, 0, 1, 16'hFFFE, 1);
    @(posedge clk); #1;
    check("bl_bundle", 64'(dut_bundle()), 64'(mk(11, 0, 32'hFFFFFFFE, 0, 0, 14, 0, 4'hE)));
    step(0, 0, 0, 16'h0, 1);

    d0 = delivered;
    step(0, 0, 1, 16'h2105, 1);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 16'h3907, 0);
      check("stall_ready", 64'(in_ready), 64'(0));
      check("stall_bundle", 64'(dut_bundle()), 64'(mk(8, 1, 32'h5, 0, 0, 1, 0, 4'hF)));
    end
    step(0, 0, 1, 16'h3907, 1);
    step(0, 0, 0, 16'h0, 1);
    check("stall_delivered", 64'(delivered - d0), 64'(2));

    step(0, 0, 1, 16'hF000, 1);
    step(0, 1, 1, 16'hF800, 1);
    step(0, 0, 0, 16'h0, 1);
    check("flush_valid", 64'(out_valid), 64'(0));
    step(0, 0, 1, 16'h2105, 1);
    @(posedge clk); #1;
    check("flush_mov", 64'(dut_bundle()), 64'(mk(8, 1, 32'h5, 0, 0, 1, 0, 4'hF)));
    step(0, 0, 0, 16'h0, 1);

    step(0, 0, 1, 16'hF000, 1);
    step(1, 0, 0, 16'h0, 1);
    step(0, 0, 0, 16'h0, 1);
    check("rst_wide_valid", 64'(out_valid), 64'(0));
    step(0, 0, 1, 16'h2105, 1);
    step(0, 0, 0, 16'h0, 1);

    step(1, 0, 0, 16'h0, 1);
    step(0, 0, 1, 16'hF000, 1);
    step(0, 0, 1, 16'hF800, 1);
    @(posedge clk); #1;
    check("nowide_valid", 64'(n_out_valid), 64'(1));
    check("nowide_bundle", 64'(n_bundle()), 64'(mk(0, 0, 32'h0, 0, 0, 0, 1, 4'hF)));
    step(0, 0, 0, 16'h0, 1);
    @(posedge clk); #1;
    check("nowide_single", 64'(n_out_valid), 64'(0));

    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 9));
      if (r < 2) h = tbl[$urandom_range(0, tbl.size() - 1)].hw;
      else if (r == 2) h = 16'hF000 | 16'($urandom_range(0, 2047));
      else if (r == 3) h = 16'hF800 | 16'($urandom_range(0, 2047));
      else h = 16'($urandom);
      step($urandom_range(0, 99) == 0, $urandom_range(0, 19) == 0,
           $urandom_range(0, 9) < 7, h, $urandom_range(0, 9) < 7);
    end
    step(0, 0, 0, 16'h0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
